data_tx_scheduler: RTL

Shares the control processor's single data-plane transmit path among NUM_REQ local requesters (GPP ports, DMA). Grants round-robin, streams each requester's burst one 16-bit word per data-plane packet, and waits for the data plane's per-packet completion before sending the next word. Sits between the requester ports and the data plane's data_tx_flag / data_tx_packet / data_tx_complete_flag interface.

---
 rtl/dp_sched_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/data_tx_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dp_sched_pkg.sv
// Shared types and packet layout for the data-plane transmit scheduler.
package dp_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT,
    DONE,
    ABORT
  } state_e;

  // Data-plane packet layout: destination node in the upper half, payload word below.
  localparam int PKT_W    = 32;
  localparam int DEST_MSB = 31;
  localparam int DEST_LSB = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
// The pointer itself is owned and advanced by the caller.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any_req
);

  localparam int IW = $clog2(N);
  localparam int SW = IW + 1;

  logic [SW-1:0] sum;
  logic [IW-1:0] idx;

  // Scan N candidates starting at ptr; the first hit wins.
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    grant_idx = '0;
    any_req   = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + SW'(i);
      if (sum >= SW'(N)) sum = sum - SW'(N);
      idx = sum[IW-1:0];
      if (!any_req && req[idx]) begin
        any_req   = 1'b1;
        grant_idx = idx;
      end
    end
  end

endmodule

// File: rtl/data_tx_scheduler.sv
// Shares the single data-plane transmit path among NUM_REQ requesters: round-robin
// grant, one word per packet, waits for per-packet completion with a timeout.
module data_tx_scheduler
  import dp_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NODE_W  = 16,
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NODE_W-1:0]         node_id,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*NODE_W-1:0] req_dest,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_pop,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [NUM_REQ-1:0]        req_err,
  output logic                      data_tx_flag,
  output logic [PKT_W-1:0]          data_tx_packet,
  input  logic                      data_tx_complete_flag,
  output logic                      busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT);

  state_e              state_q, state_d;
  logic [IW-1:0]       g_q, rr_ptr_q, grant_idx;
  logic                any_req;
  logic [NODE_W-1:0]   dest_q;
  logic [LEN_W-1:0]    len_q, cnt_q;
  logic [TW-1:0]       timer_q;
  logic [PKT_W-1:0]    pkt_q;

  logic [NODE_W-1:0]   dest_arr [NUM_REQ];
  logic [LEN_W-1:0]    len_arr  [NUM_REQ];
  logic [DATA_W-1:0]   data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign dest_arr[i] = req_dest[i*NODE_W +: NODE_W];
    assign len_arr[i]  = req_len[i*LEN_W +: LEN_W];
    assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and Moore outputs; the grant index steers the per-requester strobes.
  always_comb begin
    state_d      = state_q;
    req_pop      = '0;
    req_done     = '0;
    req_err      = '0;
    data_tx_flag = 1'b0;
    busy         = (state_q != IDLE);
    case (state_q)
      IDLE:  if (any_req) state_d = LOAD;
      LOAD:  state_d = (dest_q == node_id) ? ABORT : SEND;
      SEND: begin
        data_tx_flag = 1'b1;
        req_pop[g_q] = 1'b1;
        state_d      = WAIT;
      end
      WAIT: begin
        // Completion takes priority over a simultaneous timeout expiry.
        if (data_tx_complete_flag)            state_d = (cnt_q == len_q) ? DONE : SEND;
        else if (timer_q == TW'(TIMEOUT - 2)) state_d = ABORT;
      end
      DONE: begin
        req_done[g_q] = 1'b1;
        state_d       = IDLE;
      end
      ABORT: begin
        req_err[g_q] = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant capture, word counter, completion timer, round-robin pointer and packet register.
  // The packet is loaded on entry to SEND so it is valid in the same cycle as data_tx_flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      g_q      <= '0;
      rr_ptr_q <= '0;
      dest_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      timer_q  <= '0;
      pkt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            g_q    <= grant_idx;
            dest_q <= dest_arr[grant_idx];
            len_q  <= len_arr[grant_idx];
            cnt_q  <= '0;
          end
        end
        LOAD: begin
          if (state_d == SEND) begin
            pkt_q[DEST_MSB:DEST_LSB] <= dest_q;
            pkt_q[DATA_MSB:DATA_LSB] <= data_arr[g_q];
          end
        end
        SEND: timer_q <= '0;
        WAIT: begin
          if (data_tx_complete_flag) begin
            if (cnt_q != len_q) begin
              cnt_q                    <= cnt_q + LEN_W'(1);
              pkt_q[DEST_MSB:DEST_LSB] <= dest_q;
              pkt_q[DATA_MSB:DATA_LSB] <= data_arr[g_q];
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        DONE, ABORT: rr_ptr_q <= (g_q == IW'(NUM_REQ - 1)) ? '0 : g_q + IW'(1);
        default: ;
      endcase
    end
  end

  assign data_tx_packet = pkt_q;

endmodule
